// File: rtl/tlul_pkg.sv
// TL-UL channel structures and opcode encodings shared by crossbar devices.
package tlul_pkg;

  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;
  localparam logic [2:0] ACCESS_ACK       = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [0:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_uart_tx.sv
// TL-UL UART transmitter: CTRL/STATUS/TXDATA registers, byte FIFO and an
// 8N1 LSB-first serializer with a programmable bit period of DIV+1 cycles.
module tlul_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_d2h_t tl_o,
  output logic              tx_o,
  output logic              tx_idle_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // Control/status registers
  logic             r_tx_en;
  logic [15:0]      r_div;

  // FIFO
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             w_full;
  logic             w_empty;
  logic [4:0]       w_level5;

  // Serializer
  state_e           r_state;
  logic             r_tx;
  logic [15:0]      r_baud;
  logic [15:0]      r_div_f;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_shift;
  logic             w_tick;
  logic             w_pop;

  // Response register
  logic             r_rsp_pend;
  logic [2:0]       r_d_opcode;
  logic [1:0]       r_d_size;
  logic [7:0]       r_d_source;
  logic [31:0]      r_d_data;
  logic             r_d_error;

  // Request decode
  logic             w_acc;
  logic             w_is_get;
  logic             w_is_put;
  logic             w_addr_ok;
  logic [1:0]       w_idx;
  logic             w_err;
  logic [31:0]      w_rdata;
  logic             w_push_req;
  logic             w_ctrl_req;
  logic             w_push;
  logic             w_ctrl_we;
  logic [31:0]      w_status;
  logic             w_unused_bits;

  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_level5  = 5'(r_level);
  assign tx_idle_o = w_empty && (r_state == S_IDLE);
  assign tx_o      = r_tx;

  assign w_status  = {19'd0, w_level5, 5'd0, tx_idle_o, w_empty, w_full};

  assign w_acc     = tl_i.a_valid && !r_rsp_pend;
  assign w_is_get  = (tl_i.a_opcode == tlul_pkg::GET);
  assign w_is_put  = (tl_i.a_opcode == tlul_pkg::PUT_FULL_DATA) ||
                     (tl_i.a_opcode == tlul_pkg::PUT_PARTIAL_DATA);
  assign w_addr_ok = (tl_i.a_address[15:4] == 12'd0) && (tl_i.a_address[1:0] == 2'd0);
  assign w_idx     = tl_i.a_address[3:2];
  assign w_push    = w_acc && w_push_req;
  assign w_ctrl_we = w_acc && w_ctrl_req;

  assign w_unused_bits = ^{tl_i.a_param, tl_i.a_address[31:16], tl_i.a_data[15:1], tl_i.a_mask[1]};

  // Error/read-data/side-effect decode for the request on the A channel
  always_comb begin
    w_err      = 1'b1;
    w_rdata    = 32'd0;
    w_push_req = 1'b0;
    w_ctrl_req = 1'b0;
    if (w_is_get && w_addr_ok) begin
      case (w_idx)
        2'd0: begin w_err = 1'b0; w_rdata = {r_div, 15'd0, r_tx_en}; end
        2'd1: begin w_err = 1'b0; w_rdata = w_status; end
        2'd2: w_err = 1'b0;
        default: w_err = 1'b1;
      endcase
    end else if (w_is_put && w_addr_ok) begin
      case (w_idx)
        2'd0: begin w_err = 1'b0; w_ctrl_req = 1'b1; end
        2'd2: begin
          if (tl_i.a_mask[0] && !w_full) begin
            w_err      = 1'b0;
            w_push_req = 1'b1;
          end
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  // Single-entry response register; one outstanding transaction at a time
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_pend <= 1'b0;
      r_d_opcode <= 3'd0;
      r_d_size   <= 2'd0;
      r_d_source <= 8'd0;
      r_d_data   <= 32'd0;
      r_d_error  <= 1'b0;
    end else if (w_acc) begin
      r_rsp_pend <= 1'b1;
      r_d_opcode <= w_is_get ? tlul_pkg::ACCESS_ACK_DATA : tlul_pkg::ACCESS_ACK;
      r_d_size   <= tl_i.a_size;
      r_d_source <= tl_i.a_source;
      r_d_data   <= w_rdata;
      r_d_error  <= w_err;
    end else if (r_rsp_pend && tl_i.d_ready) begin
      r_rsp_pend <= 1'b0;
    end
  end

  // Drive the D channel and a_ready from the response register
  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = !r_rsp_pend;
    tl_o.d_valid  = r_rsp_pend;
    tl_o.d_opcode = r_d_opcode;
    tl_o.d_size   = r_d_size;
    tl_o.d_source = r_d_source;
    tl_o.d_data   = r_d_data;
    tl_o.d_error  = r_d_error;
  end

  // CTRL register writes, honouring byte-lane masks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_en <= 1'b0;
      r_div   <= DEFAULT_DIV;
    end else if (w_ctrl_we) begin
      if (tl_i.a_mask[0]) r_tx_en     <= tl_i.a_data[0];
      if (tl_i.a_mask[2]) r_div[7:0]  <= tl_i.a_data[23:16];
      if (tl_i.a_mask[3]) r_div[15:8] <= tl_i.a_data[31:24];
    end
  end

  // FIFO storage; pushes are already blocked when full
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= tl_i.a_data[7:0];
  end

  // FIFO pointers and level; simultaneous push/pop keeps level constant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Pop either from IDLE or on the last STOP cycle so frames run back-to-back
  assign w_tick = (r_baud == 16'd0);
  assign w_pop  = r_tx_en && !w_empty &&
                  ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));

  // Frame datapath: load byte and frame divider on pop, shift at bit boundaries
  always_ff @(posedge clk_i) begin
    if (w_pop) begin
      r_shift <= r_mem[r_rptr];
      r_div_f <= r_div;
    end else if (((r_state == S_START) || (r_state == S_DATA)) && w_tick) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  // Serializer FSM with registered line output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_baud   <= 16'd0;
      r_bitcnt <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_START;
            r_baud  <= r_div;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_state  <= S_DATA;
            r_baud   <= r_div_f;
            r_bitcnt <= 3'd0;
            r_tx     <= r_shift[0];
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_baud <= r_div_f;
            if (r_bitcnt == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
              r_tx     <= r_shift[0];
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_pop) begin
              r_state <= S_START;
              r_baud  <= r_div;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlul_uart_tx.sv
// Self-checking bench for tlul_uart_tx: register access, framing, FIFO
// limits, error decoding, response back-pressure and mid-frame reset.
module tb_tlul_uart_tx;

  localparam int DEPTH = 8;

  logic              clk;
  logic              rst_ni;
  tlul_pkg::tl_h2d_t tl_i;
  tlul_pkg::tl_d2h_t tl_o;
  logic              tx_o;
  logic              tx_idle_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic        m_en;
  logic [15:0] m_div;
  logic [7:0]  exp_bytes[$];

  tlul_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd867)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .tl_i      (tl_i),
    .tl_o      (tl_o),
    .tx_o      (tx_o),
    .tx_idle_o (tx_idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_status(input int lvl, input bit idle);
    return (lvl << 8) | (int'(idle) << 2) | (int'(lvl == 0) << 1) | int'(lvl == DEPTH);
  endfunction

  function automatic logic [31:0] ctrl_word(input logic [15:0] div, input logic en);
    return {div, 15'd0, en};
  endfunction

  // One complete TL-UL transaction with d_ready held high
  task automatic bus(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] wdata, input logic [7:0] src,
                     output logic [31:0] rdata, output logic err, output logic [2:0] dop,
                     output logic [7:0] dsrc, output logic [1:0] dsz, output logic lat1);
    int n;
    @(negedge clk);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = wdata;
    tl_i.a_source  = src;
    tl_i.a_size    = 2'd2;
    tl_i.d_ready   = 1'b1;
    n = 0;
    while (tl_o.a_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL bus_a_ready_timeout: a_ready=%b required 1", tl_o.a_ready);
    end
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    lat1 = (tl_o.d_valid === 1'b1);
    n = 0;
    while (tl_o.d_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL bus_d_valid_timeout: d_valid=%b required 1", tl_o.d_valid);
    end
    rdata = tl_o.d_data;
    err   = tl_o.d_error;
    dop   = tl_o.d_opcode;
    dsrc  = tl_o.d_source;
    dsz   = tl_o.d_size;
    @(posedge clk); #1;
  endtask

  // Watch the line from the first start-bit cycle for exp_bytes frames
  task automatic rx_frames(input int div);
    int nfr;
    nfr = exp_bytes.size();
    for (int f = 0; f < nfr; f++) begin
      logic [9:0] expf;
      logic [9:0] obs;
      int nbad;
      expf = {1'b1, exp_bytes[f], 1'b0};
      obs  = '0;
      nbad = 0;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c <= div; c++) begin
          if (c == div / 2) obs[b] = tx_o;
          if (tx_o !== expf[b] || tx_idle_o !== 1'b0) nbad++;
          @(posedge clk); #1;
        end
      end
      n_cmp++;
      if (obs !== expf || nbad != 0) begin
        n_bad++;
        $display("FAIL frame%0d: line=%b with %0d bad cycles, required %b with 0", f, obs, nbad, expf);
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic er; logic [2:0] op; logic [7:0] sr; logic [1:0] sz; logic l1;
    logic [7:0] src;
    n_cmp++;
    if (tl_o.a_ready !== 1'b1 || tl_o.d_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_handshake: a_ready=%b d_valid=%b required 1 0", tl_o.a_ready, tl_o.d_valid);
    end
    n_cmp++;
    if (tl_o.d_data !== 32'd0 || tl_o.d_error !== 1'b0 || tl_o.d_source !== 8'd0) begin
      n_bad++; $display("FAIL rst_dfields: data=%h err=%b src=%h required 0", tl_o.d_data, tl_o.d_error, tl_o.d_source);
    end
    n_cmp++;
    if (tx_o !== 1'b1 || tx_idle_o !== 1'b1) begin
      n_bad++; $display("FAIL rst_line: tx=%b idle=%b required 1 1", tx_o, tx_idle_o);
    end
    src = 8'($urandom);
    bus(tlul_pkg::GET, 32'h4, 4'hF, 32'd0, src, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (rd !== exp_status(0, 1'b1)) begin
      n_bad++; $display("FAIL rst_status: got %h required %h", rd, exp_status(0, 1'b1));
    end
    n_cmp++;
    if (er !== 1'b0 || op !== tlul_pkg::ACCESS_ACK_DATA) begin
      n_bad++; $display("FAIL rst_get_rsp: err=%b op=%0d required 0 1", er, op);
    end
    n_cmp++;
    if (l1 !== 1'b1) begin
      n_bad++; $display("FAIL rst_latency: d_valid next cycle=%b required 1", l1);
    end
    n_cmp++;
    if (sr !== src || sz !== 2'd2) begin
      n_bad++; $display("FAIL rst_echo: src=%h size=%0d required %h 2", sr, sz, src);
    end
    bus(tlul_pkg::GET, 32'h0, 4'hF, 32'd0, 8'h11, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (rd !== ctrl_word(m_div, m_en)) begin
      n_bad++; $display("FAIL rst_ctrl: got %h required %h", rd, ctrl_word(m_div, m_en));
    end
  endtask

  task automatic test_frame(input logic [7:0] byte_v, input logic [15:0] div);
    logic [31:0] rd; logic er; logic [2:0] op; logic [7:0] sr; logic [1:0] sz; logic l1;
    m_en = 1'b1; m_div = div;
    bus(tlul_pkg::PUT_FULL_DATA, 32'h0, 4'hF, ctrl_word(div, 1'b1), 8'h21, rd, er, op, sr, sz, l1);
    bus(tlul_pkg::PUT_FULL_DATA, 32'h8, 4'h1, {24'($urandom), byte_v}, 8'h22, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (er !== 1'b0 || op !== tlul_pkg::ACCESS_ACK || rd !== 32'd0) begin
      n_bad++; $display("FAIL frame_push_rsp: err=%b op=%0d data=%h required 0 0 0", er, op, rd);
    end
    exp_bytes.delete();
    exp_bytes.push_back(byte_v);
    rx_frames(int'(div));
    n_cmp++;
    if (tx_idle_o !== 1'b1 || tx_o !== 1'b1) begin
      n_bad++; $display("FAIL frame_end_idle: idle=%b tx=%b required 1 1", tx_idle_o, tx_o);
    end
  endtask

  task automatic test_fifo_full;
    logic [31:0] rd; logic [31:0] st; logic er; logic [2:0] op; logic [7:0] sr; logic [1:0] sz; logic l1;
    logic [15:0] div;
    logic [7:0] b;
    div = 16'($urandom_range(0, 3));
    m_en = 1'b0; m_div = div;
    bus(tlul_pkg::PUT_FULL_DATA, 32'h0, 4'hF, ctrl_word(div, 1'b0), 8'h31, rd, er, op, sr, sz, l1);
    exp_bytes.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      bus(tlul_pkg::PUT_PARTIAL_DATA, 32'h8, 4'h1, {24'd0, b}, 8'(i), rd, er, op, sr, sz, l1);
      n_cmp++;
      if (er !== (i >= DEPTH)) begin
        n_bad++; $display("FAIL fifo_push%0d_err: got %b required %b", i, er, (i >= DEPTH));
      end
      if (exp_bytes.size() < DEPTH) exp_bytes.push_back(b);
    end
    bus(tlul_pkg::GET, 32'h4, 4'hF, 32'd0, 8'h32, st, er, op, sr, sz, l1);
    n_cmp++;
    if (st !== exp_status(DEPTH, 1'b0)) begin
      n_bad++; $display("FAIL fifo_full_status: got %h required %h", st, exp_status(DEPTH, 1'b0));
    end
    m_en = 1'b1;
    bus(tlul_pkg::PUT_FULL_DATA, 32'h0, 4'hF, ctrl_word(div, 1'b1), 8'h33, rd, er, op, sr, sz, l1);
    rx_frames(int'(div));
    bus(tlul_pkg::GET, 32'h4, 4'hF, 32'd0, 8'h34, st, er, op, sr, sz, l1);
    n_cmp++;
    if (st !== exp_status(0, 1'b1)) begin
      n_bad++; $display("FAIL fifo_drained_status: got %h required %h", st, exp_status(0, 1'b1));
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; logic [2:0] op; logic [7:0] sr; logic [1:0] sz; logic l1;
    logic [7:0] lo;
    bus(tlul_pkg::GET, 32'hC, 4'hF, 32'd0, 8'h41, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      n_bad++; $display("FAIL err_get_c: err=%b data=%h required 1 0", er, rd);
    end
    bus(tlul_pkg::PUT_FULL_DATA, 32'h4, 4'hF, 32'hFFFF_FFFF, 8'h42, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (er !== 1'b1 || op !== tlul_pkg::ACCESS_ACK) begin
      n_bad++; $display("FAIL err_put_status: err=%b op=%0d required 1 0", er, op);
    end
    bus(tlul_pkg::PUT_PARTIAL_DATA, 32'h8, 4'hE, 32'h5A5A_5A5A, 8'h43, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (er !== 1'b1) begin
      n_bad++; $display("FAIL err_put_mask: err=%b required 1", er);
    end
    bus(tlul_pkg::GET, 32'h10, 4'hF, 32'd0, 8'h44, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (er !== 1'b1) begin
      n_bad++; $display("FAIL err_get_10: err=%b required 1", er);
    end
    bus(tlul_pkg::GET, 32'h1, 4'hF, 32'd0, 8'h45, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (er !== 1'b1) begin
      n_bad++; $display("FAIL err_misaligned: err=%b required 1", er);
    end
    bus(3'd2, 32'h0, 4'hF, 32'd0, 8'h46, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (er !== 1'b1 || op !== tlul_pkg::ACCESS_ACK || rd !== 32'd0) begin
      n_bad++; $display("FAIL err_bad_opcode: err=%b op=%0d data=%h required 1 0 0", er, op, rd);
    end
    bus(tlul_pkg::GET, 32'h0, 4'hF, 32'd0, 8'h47, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (rd !== ctrl_word(m_div, m_en)) begin
      n_bad++; $display("FAIL err_ctrl_kept: got %h required %h", rd, ctrl_word(m_div, m_en));
    end
    bus(tlul_pkg::GET, 32'h4, 4'hF, 32'd0, 8'h48, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (rd !== exp_status(0, 1'b1)) begin
      n_bad++; $display("FAIL err_status_kept: got %h required %h", rd, exp_status(0, 1'b1));
    end
    bus(tlul_pkg::GET, 32'h8, 4'hF, 32'd0, 8'h49, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (er !== 1'b0 || rd !== 32'd0) begin
      n_bad++; $display("FAIL txdata_read: err=%b data=%h required 0 0", er, rd);
    end
    lo = 8'($urandom);
    m_div = {m_div[15:8], lo};
    bus(tlul_pkg::PUT_PARTIAL_DATA, 32'h0, 4'h4, {8'hFF, lo, 16'h0000}, 8'h4A, rd, er, op, sr, sz, l1);
    bus(tlul_pkg::GET, 32'h0, 4'hF, 32'd0, 8'h4B, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (rd !== ctrl_word(m_div, m_en)) begin
      n_bad++; $display("FAIL ctrl_lane_mask: got %h required %h", rd, ctrl_word(m_div, m_en));
    end
  endtask

  task automatic test_back_pressure;
    logic [7:0] src1, src2;
    int nbad;
    src1 = 8'($urandom);
    src2 = src1 ^ 8'h5C;
    @(negedge clk);
    tl_i.a_valid = 1'b1; tl_i.a_opcode = tlul_pkg::GET; tl_i.a_address = 32'h4;
    tl_i.a_mask = 4'hF; tl_i.a_source = src1; tl_i.a_size = 2'd2; tl_i.d_ready = 1'b0;
    @(posedge clk); #1;
    tl_i.a_address = 32'h0;
    tl_i.a_source  = src2;
    nbad = 0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (tl_o.d_valid !== 1'b1 || tl_o.d_source !== src1 || tl_o.a_ready !== 1'b0 ||
          tl_o.d_data !== exp_status(0, 1'b1)) begin
        n_bad++;
        $display("FAIL stall_cycle%0d: d_valid=%b src=%h a_ready=%b data=%h required 1 %h 0 %h",
                 i, tl_o.d_valid, tl_o.d_source, tl_o.a_ready, tl_o.d_data, src1, exp_status(0, 1'b1));
      end
      @(posedge clk); #1;
    end
    tl_i.d_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (tl_o.d_valid !== 1'b0 || tl_o.a_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_release: d_valid=%b a_ready=%b required 0 1", tl_o.d_valid, tl_o.a_ready);
    end
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    n_cmp++;
    if (tl_o.d_valid !== 1'b1 || tl_o.d_source !== src2 || tl_o.d_data !== ctrl_word(m_div, m_en)) begin
      n_bad++; $display("FAIL stall_second: d_valid=%b src=%h data=%h required 1 %h %h",
                        tl_o.d_valid, tl_o.d_source, tl_o.d_data, src2, ctrl_word(m_div, m_en));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] rd; logic er; logic [2:0] op; logic [7:0] sr; logic [1:0] sz; logic l1;
    int nbad;
    m_en = 1'b1; m_div = 16'd3;
    bus(tlul_pkg::PUT_FULL_DATA, 32'h0, 4'hF, ctrl_word(16'd3, 1'b1), 8'h51, rd, er, op, sr, sz, l1);
    bus(tlul_pkg::PUT_FULL_DATA, 32'h8, 4'h1, 32'h0000_0000, 8'h52, rd, er, op, sr, sz, l1);
    bus(tlul_pkg::PUT_FULL_DATA, 32'h8, 4'h1, 32'h0000_00C3, 8'h53, rd, er, op, sr, sz, l1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    tl_i.a_valid = 1'b1; tl_i.a_opcode = tlul_pkg::GET; tl_i.a_address = 32'h4;
    tl_i.a_source = 8'h54; tl_i.d_ready = 1'b0;
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    m_en = 1'b0; m_div = 16'd867;
    n_cmp++;
    if (tx_o !== 1'b1 || tx_idle_o !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_line: tx=%b idle=%b required 1 1", tx_o, tx_idle_o);
    end
    n_cmp++;
    if (tl_o.d_valid !== 1'b0 || tl_o.a_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_rsp: d_valid=%b a_ready=%b required 0 1", tl_o.d_valid, tl_o.a_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    tl_i.d_ready = 1'b1;
    nbad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (tl_o.d_valid !== 1'b0 || tx_o !== 1'b1) nbad++;
    end
    n_cmp++;
    if (nbad != 0) begin
      n_bad++; $display("FAIL rstmid_quiet: %0d cycles with response or low line, required 0", nbad);
    end
    bus(tlul_pkg::GET, 32'h4, 4'hF, 32'd0, 8'h55, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (rd !== exp_status(0, 1'b1)) begin
      n_bad++; $display("FAIL rstmid_status: got %h required %h", rd, exp_status(0, 1'b1));
    end
    bus(tlul_pkg::GET, 32'h0, 4'hF, 32'd0, 8'h56, rd, er, op, sr, sz, l1);
    n_cmp++;
    if (rd !== ctrl_word(m_div, m_en)) begin
      n_bad++; $display("FAIL rstmid_ctrl: got %h required %h", rd, ctrl_word(m_div, m_en));
    end
  endtask

  initial begin
    tl_i   = '0;
    rst_ni = 1'b0;
    m_en   = 1'b0;
    m_div  = 16'd867;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_frame(8'hA5, 16'd3);
    test_frame(8'($urandom), 16'($urandom_range(0, 5)));
    test_fifo_full();
    test_errors();
    test_back_pressure();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
